// File: rtl/debug_step_ctrl.sv
// Debug run/step/burst controller producing a registered clock enable for a core.
// Define DBG_BREAKPOINT_EN to build the run-to-breakpoint (RUN_BP/HALT) support.
module debug_step_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step_key_n,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              core_ce,
    output logic              running,
    output logic              halted_at_bp,
    output logic [CNT_W-1:0]  step_count
);

    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

    localparam logic [1:0] ModeFree  = 2'b00;
    localparam logic [1:0] ModeBurst = 2'b10;
`ifdef DBG_BREAKPOINT_EN
    localparam logic [1:0] ModeBp    = 2'b11;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
`ifdef DBG_BREAKPOINT_EN
        StRunBp,
        StHalt,
`endif
        StBurst
    } state_e;

    logic [1:0]       sync_q;
    logic             key_s;
    logic             db_level_q;
    logic [DbW-1:0]   db_cnt_q;
    logic             press_q;
    state_e           state_q;
    logic [CNT_W-1:0] burst_cnt_q;
`ifdef DBG_BREAKPOINT_EN
    logic             suppress_q;
`else
    logic             unused_bp;
    assign unused_bp = ^{pc, pc_valid, bp_addr};
`endif

    assign key_s = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], step_key_n};
        end
    end

    // A level is accepted only after DbLast+1 consecutive samples that differ from it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (key_s != db_level_q) begin
                if (db_cnt_q == DbLast) begin
                    db_level_q <= key_s;
                    db_cnt_q   <= '0;
                    press_q    <= ~key_s;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            core_ce      <= 1'b0;
            running      <= 1'b0;
            halted_at_bp <= 1'b0;
            step_count   <= '0;
            burst_cnt_q  <= '0;
`ifdef DBG_BREAKPOINT_EN
            suppress_q   <= 1'b0;
`endif
        end else begin
            if (core_ce) begin
                step_count <= step_count + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (mode == ModeFree) begin
                        state_q <= StRun;
                        core_ce <= 1'b1;
                        running <= 1'b1;
                    end else if (press_q) begin
                        if (mode == ModeBurst) begin
                            if (burst_len != '0) begin
                                state_q     <= StBurst;
                                burst_cnt_q <= burst_len;
                                core_ce     <= 1'b1;
                                running     <= 1'b1;
                            end
`ifdef DBG_BREAKPOINT_EN
                        end else if (mode == ModeBp) begin
                            state_q    <= StRunBp;
                            core_ce    <= 1'b1;
                            running    <= 1'b1;
                            suppress_q <= 1'b0;
`endif
                        end else begin
                            state_q <= StStep;
                            core_ce <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (mode != ModeFree) begin
                        state_q <= StIdle;
                        core_ce <= 1'b0;
                        running <= 1'b0;
                    end
                end
                StStep: begin
                    state_q <= StIdle;
                    core_ce <= 1'b0;
                end
                StBurst: begin
                    burst_cnt_q <= burst_cnt_q - 1'b1;
                    if (mode != ModeBurst || burst_cnt_q == CNT_W'(1)) begin
                        state_q     <= StIdle;
                        core_ce     <= 1'b0;
                        running     <= 1'b0;
                        burst_cnt_q <= '0;
                    end
                end
`ifdef DBG_BREAKPOINT_EN
                StRunBp: begin
                    suppress_q <= 1'b0;
                    if (mode != ModeBp) begin
                        state_q <= StIdle;
                        core_ce <= 1'b0;
                        running <= 1'b0;
                    end else if (pc_valid && pc == bp_addr && !suppress_q) begin
                        state_q      <= StHalt;
                        core_ce      <= 1'b0;
                        running      <= 1'b0;
                        halted_at_bp <= 1'b1;
                    end
                end
                StHalt: begin
                    if (mode != ModeBp) begin
                        state_q      <= StIdle;
                        halted_at_bp <= 1'b0;
                    end else if (press_q) begin
                        // The core re-presents the halted pc; skip matching it once.
                        state_q      <= StRunBp;
                        core_ce      <= 1'b1;
                        running      <= 1'b1;
                        halted_at_bp <= 1'b0;
                        suppress_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q      <= StIdle;
                    core_ce      <= 1'b0;
                    running      <= 1'b0;
                    halted_at_bp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed, table-driven bench for debug_step_ctrl (DB_CYCLES=4, CNT_W=8).
module tb_debug_step_ctrl;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned DB_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              step_key_n;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  burst_len;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic [ADDR_W-1:0] bp_addr;
    logic              core_ce;
    logic              running;
    logic              halted_at_bp;
    logic [CNT_W-1:0]  step_count;

    debug_step_ctrl #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_key_n  (step_key_n),
        .mode        (mode),
        .burst_len   (burst_len),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .bp_addr     (bp_addr),
        .core_ce     (core_ce),
        .running     (running),
        .halted_at_bp(halted_at_bp),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic [CNT_W-1:0] bl;
        logic             pv;
        int               exp_pulses;
        logic             exp_halt;
    } vec_t;

    vec_t              vecs[6];
    int                total = 0;
    int                bad = 0;
    int                ce_seen;
    int                ce_groups;
    int                key_hold;
    int                first_idx;
    int                n;
    logic              last_ce;
    logic [ADDR_W-1:0] cur_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock; pc advances by 4 after each enabled cycle unless the core is halted.
    task automatic tick();
        @(posedge clk);
        #1;
        if (key_hold > 0) begin
            key_hold--;
            if (key_hold == 0) step_key_n = 1'b1;
        end
        if (last_ce && !halted_at_bp) cur_pc += 4;
        pc = cur_pc;
        if (core_ce) begin
            ce_seen++;
            if (!last_ce) ce_groups++;
        end
        last_ce = core_ce;
    endtask

    task automatic press();
        step_key_n = 1'b0;
        key_hold   = 10;
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset_n    = 1'b0;
        mode       = m;
        step_key_n = 1'b1;
        key_hold   = 0;
        cur_pc     = '0;
        pc         = '0;
        last_ce    = 1'b0;
        ce_seen    = 0;
        ce_groups  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_ce(input string name);
        int k;
        k = 0;
        while (!core_ce && k < 30) begin
            tick();
            k++;
        end
        check(name, 32'(core_ce), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode: 2'b01, bl: 8'd5, pv: 1'b0, exp_pulses: 1, exp_halt: 1'b0};
        vecs[1] = '{mode: 2'b10, bl: 8'd5, pv: 1'b0, exp_pulses: 5, exp_halt: 1'b0};
        vecs[2] = '{mode: 2'b10, bl: 8'd0, pv: 1'b0, exp_pulses: 0, exp_halt: 1'b0};
        vecs[3] = '{mode: 2'b10, bl: 8'd1, pv: 1'b0, exp_pulses: 1, exp_halt: 1'b0};
        vecs[4] = '{mode: 2'b10, bl: 8'd3, pv: 1'b0, exp_pulses: 3, exp_halt: 1'b0};
`ifdef DBG_BREAKPOINT_EN
        vecs[5] = '{mode: 2'b11, bl: 8'd4, pv: 1'b1, exp_pulses: 1, exp_halt: 1'b1};
`else
        vecs[5] = '{mode: 2'b11, bl: 8'd4, pv: 1'b1, exp_pulses: 1, exp_halt: 1'b0};
`endif
        burst_len = '0;
        pc_valid  = 1'b0;
        bp_addr   = '0;

        // Reset state
        do_reset(2'b01);
        check("rst_core_ce", 32'(core_ce), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted_at_bp), 32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);

        // Press latency: 2 sync + 4 debounce + press pulse, enable on the 7th edge
        press();
        first_idx = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (core_ce && first_idx == 0) first_idx = i;
        end
        check("latency_first_ce", 32'(first_idx), 32'd7);
        check("latency_pulses", 32'(ce_seen), 32'd1);
        check("latency_step_count", 32'(step_count), 32'd1);

        // Short glitches must not register as a press
        do_reset(2'b01);
        for (int g = 0; g < 2; g++) begin
            step_key_n = 1'b0;
            tick();
            tick();
            step_key_n = 1'b1;
            tick();
            tick();
        end
        repeat (10) tick();
        check("glitch_no_pulse", 32'(ce_seen), 32'd0);
        press();
        repeat (40) tick();
        check("glitch_press_pulses", 32'(ce_seen), 32'd1);
        check("glitch_step_count", 32'(step_count), 32'd1);

        // Table: one press per mode/burst_len and expected enable count
        for (int i = 0; i < 6; i++) begin
            do_reset(2'b01);
            mode      = vecs[i].mode;
            burst_len = vecs[i].bl;
            pc_valid  = vecs[i].pv;
            bp_addr   = '0;
            press();
            repeat (40) tick();
            check($sformatf("vec%0d_pulses", i), 32'(ce_seen), 32'(vecs[i].exp_pulses));
            check($sformatf("vec%0d_groups", i), 32'(ce_groups),
                  (vecs[i].exp_pulses > 0) ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_step_count", i), 32'(step_count),
                  32'(vecs[i].exp_pulses));
            check($sformatf("vec%0d_halted", i), 32'(halted_at_bp), 32'(vecs[i].exp_halt));
            check($sformatf("vec%0d_running", i), 32'(running), 32'd0);
        end
        pc_valid = 1'b0;

        // Burst aborted by a mode change after 3 enabled cycles
        do_reset(2'b01);
        mode      = 2'b10;
        burst_len = 8'd10;
        press();
        wait_ce("abort_first_ce");
        tick();
        tick();
        mode = 2'b01;
        tick();
        check("abort_ce_off", 32'(core_ce), 32'd0);
        repeat (10) tick();
        check("abort_pulses", 32'(ce_seen), 32'd3);
        check("abort_step_count", 32'(step_count), 32'd3);
        check("abort_running", 32'(running), 32'd0);

        // Reset in the third burst cycle clears outputs at once
        do_reset(2'b01);
        mode      = 2'b10;
        burst_len = 8'd10;
        press();
        wait_ce("rstburst_first_ce");
        tick();
        tick();
        check("rstburst_pre_count", 32'(step_count), 32'd2);
        reset_n = 1'b0;
        #1;
        check("rstburst_ce", 32'(core_ce), 32'd0);
        check("rstburst_step_count", 32'(step_count), 32'd0);
        check("rstburst_running", 32'(running), 32'd0);
        do_reset(2'b10);
        repeat (20) tick();
        check("rstburst_after_pulses", 32'(ce_seen), 32'd0);

        // Free run for 300 enabled cycles: 8-bit counter wraps to 44
        do_reset(2'b00);
        tick();
        check("run_first_ce", 32'(core_ce), 32'd1);
        check("run_running", 32'(running), 32'd1);
        repeat (299) tick();
        mode = 2'b01;
        tick();
        check("run_stop_ce", 32'(core_ce), 32'd0);
        check("run_pulses", 32'(ce_seen), 32'd300);
        check("run_wrap_count", 32'(step_count), 32'd44);

`ifdef DBG_BREAKPOINT_EN
        // Halt at 0x40 after 17 enabled cycles, then resume past it
        do_reset(2'b11);
        bp_addr  = 32'h40;
        pc_valid = 1'b1;
        press();
        n = 0;
        while (!halted_at_bp && n < 80) begin
            tick();
            n++;
        end
        check("bp_halted", 32'(halted_at_bp), 32'd1);
        check("bp_pulses", 32'(ce_seen), 32'd17);
        check("bp_step_count", 32'(step_count), 32'd17);
        check("bp_ce_off", 32'(core_ce), 32'd0);
        ce_seen = 0;
        press();
        wait_ce("bp_resume_ce");
        repeat (6) tick();
        check("bp_resume_halted", 32'(halted_at_bp), 32'd0);
        check("bp_resume_ce_on", 32'(core_ce), 32'd1);
        check("bp_resume_pulses", 32'(ce_seen), 32'd7);
        pc_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
